// File: rtl/dtd_bin_sched_if.sv
// Bin scheduler bus bundle: requester, DRAM read port, DTD datapath and
// downstream handshake. The slave modport is the scheduler's view.
interface dtd_bin_sched_if #(
  parameter int ADDR_W = 32
);
  logic              bin_req;
  logic [ADDR_W-1:0] bin_base;
  logic              bin_busy;
  logic              bin_done;
  logic              bin_err;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [8:0]        rd_size;
  logic              dtd_en;
  logic              dtd_data_ready;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        line_cnt;

  modport slave (
    input  bin_req, bin_base, rd_gnt, rd_valid, rd_size, dtd_data_ready, out_ready,
    output bin_busy, bin_done, bin_err, rd_req, rd_addr, dtd_en, out_valid, line_cnt
  );

  modport master (
    output bin_req, bin_base, rd_gnt, rd_valid, rd_size, dtd_data_ready, out_ready,
    input  bin_busy, bin_done, bin_err, rd_req, rd_addr, dtd_en, out_valid, line_cnt
  );
endinterface

// File: rtl/dtd_bin_sched.sv
// Decompress-then-decrypt bin scheduler: one line in flight from DRAM fetch to drain.
// Optional macro DTD_SCHED_PERF_EN adds busy-cycle and drain-stall counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for bin_req
// REQ       | rd_req high at the current line address until rd_gnt
// WAIT_DATA | waiting for rd_valid; zero-size line aborts to ERR
// WAIT_DTD  | dtd_en fired on entry; waiting for dtd_data_ready or timeout
// DRAIN     | out_valid high until out_ready; accumulate size, step address
// CHECK     | compare accumulated size against BIN_SIZE
// DONE      | one-cycle bin_done pulse
// ERR       | one-cycle bin_err pulse
module dtd_bin_sched #(
  parameter int BIN_SIZE    = 400,
  parameter int ADDR_W      = 32,
  parameter int LINE_STRIDE = 32,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst,
  dtd_bin_sched_if.slave   bus
`ifdef DTD_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stall
`endif
);

  localparam int ACC_W = 10;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_WAIT_DATA, S_WAIT_DTD, S_DRAIN, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ACC_W-1:0]  r_acc;
  logic [7:0]        r_line_cnt;
  logic [8:0]        r_size;
  logic [TMR_W-1:0]  r_tmr;
  logic              r_dtd_en;
  logic              w_accept;
  logic              w_fire;
  logic              w_drain_hs;
  logic              w_busy;

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_fire     = 1'b0;
    w_drain_hs = 1'b0;
    case (r_state)
      S_IDLE:
        if (bus.bin_req) begin
          w_accept = 1'b1;
          w_next   = S_REQ;
        end
      S_REQ:
        if (bus.rd_gnt) w_next = S_WAIT_DATA;
      S_WAIT_DATA:
        if (bus.rd_valid) begin
          if (bus.rd_size == 9'd0) begin
            w_next = S_ERR;
          end else begin
            w_fire = 1'b1;
            w_next = S_WAIT_DTD;
          end
        end
      // a ready arriving on the terminal-count cycle still wins
      S_WAIT_DTD:
        if (bus.dtd_data_ready)     w_next = S_DRAIN;
        else if (r_tmr == '0)       w_next = S_ERR;
      S_DRAIN:
        if (bus.out_ready) begin
          w_drain_hs = 1'b1;
          w_next     = S_CHECK;
        end
      S_CHECK:
        w_next = (r_acc >= ACC_W'(BIN_SIZE)) ? S_DONE : S_REQ;
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_acc      <= '0;
      r_line_cnt <= '0;
      r_size     <= '0;
      r_tmr      <= '0;
      r_dtd_en   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_dtd_en <= w_fire;
      if (w_accept) begin
        r_addr     <= bus.bin_base;
        r_acc      <= '0;
        r_line_cnt <= '0;
      end
      if (r_state == S_WAIT_DATA && bus.rd_valid) r_size <= bus.rd_size;
      if (w_fire)
        r_tmr <= TMR_W'(TIMEOUT - 1);
      else if (r_state == S_WAIT_DTD && r_tmr != '0)
        r_tmr <= r_tmr - 1'b1;
      if (w_drain_hs) begin
        r_acc  <= r_acc + ACC_W'(r_size);
        r_addr <= r_addr + ADDR_W'(LINE_STRIDE);
        if (r_line_cnt != 8'hFF) r_line_cnt <= r_line_cnt + 8'd1;
      end
    end
  end

  assign w_busy = (r_state == S_REQ) || (r_state == S_WAIT_DATA) || (r_state == S_WAIT_DTD) ||
                  (r_state == S_DRAIN) || (r_state == S_CHECK);

  assign bus.bin_busy  = w_busy;
  assign bus.bin_done  = (r_state == S_DONE);
  assign bus.bin_err   = (r_state == S_ERR);
  assign bus.rd_req    = (r_state == S_REQ);
  assign bus.rd_addr   = r_addr;
  assign bus.dtd_en    = r_dtd_en;
  assign bus.out_valid = (r_state == S_DRAIN);
  assign bus.line_cnt  = r_line_cnt;

`ifdef DTD_SCHED_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_busy && r_perf_cycles != '1) r_perf_cycles <= r_perf_cycles + 32'd1;
      if (r_state == S_DRAIN && !bus.out_ready && r_perf_stall != '1)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_dtd_bin_sched.sv
// Self-checking bench for dtd_bin_sched: reactive DRAM/DTD/consumer model with
// randomized delays, a prefix-sum bin model and a negedge event monitor.
module tb_dtd_bin_sched;

  localparam int BIN    = 400;
  localparam int STRIDE = 32;
  localparam int TMO    = 64;

  typedef logic [8:0] sz_q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dtd_bin_sched_if #(.ADDR_W(32)) bus ();

`ifdef DTD_SCHED_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_stall;
`endif

  dtd_bin_sched #(
    .BIN_SIZE(BIN), .ADDR_W(32), .LINE_STRIDE(STRIDE), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef DTD_SCHED_PERF_EN
    ,
    .perf_cycles(perf_cycles),
    .perf_stall(perf_stall)
`endif
  );

  int checks   = 0;
  int failures = 0;

  int n_dtd  = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_ovl  = 0;
  logic prev_req = 1'b0;
  logic [31:0] q_addr[$];

  always @(negedge clk) begin
    if (rst) begin
      prev_req <= 1'b0;
    end else begin
      if (bus.dtd_en) n_dtd <= n_dtd + 1;
      if (bus.bin_done) n_done <= n_done + 1;
      if (bus.bin_err) n_err <= n_err + 1;
      if (bus.dtd_en && bus.out_valid) n_ovl <= n_ovl + 1;
      if (bus.rd_req && !prev_req) q_addr.push_back(bus.rd_addr);
      prev_req <= bus.rd_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic start_bin(input logic [31:0] base);
    bus.bin_base = base;
    bus.bin_req  = 1'b1;
    @(negedge clk);
    bus.bin_req  = 1'b0;
    bus.bin_base = $urandom;
  endtask

  // Waits for rd_req, grants it, then presents one line; ends on the dtd_en cycle.
  task automatic serve_line(input logic [8:0] sz, input int lat, input int gd, input int vd,
                            output bit ok);
    int w = 0;
    logic [31:0] a;
    logic exp_en;
    ok = 1'b0;
    while (!bus.rd_req && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (bus.rd_req !== 1'b1) begin
      failures++;
      $display("FAIL rd_req_wait got=%0b exp=1", bus.rd_req);
      return;
    end
    if (lat >= 0) begin
      checks++;
      if (w !== lat) begin
        failures++;
        $display("FAIL rd_req_latency got=%0d exp=%0d", w, lat);
      end
    end
    a = bus.rd_addr;
    repeat (gd) begin
      @(negedge clk);
      checks++;
      if (bus.rd_req !== 1'b1 || bus.rd_addr !== a) begin
        failures++;
        $display("FAIL rd_req_hold got=%0b/%h exp=1/%h", bus.rd_req, bus.rd_addr, a);
      end
    end
    bus.rd_gnt = 1'b1;
    @(negedge clk);
    bus.rd_gnt = 1'b0;
    checks++;
    if (bus.rd_req !== 1'b0) begin
      failures++;
      $display("FAIL rd_req_drop got=%0b exp=0", bus.rd_req);
    end
    repeat (vd) @(negedge clk);
    bus.rd_valid = 1'b1;
    bus.rd_size  = sz;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    bus.rd_size  = 9'($urandom);
    exp_en = (sz != 9'd0);
    checks++;
    if (bus.dtd_en !== exp_en) begin
      failures++;
      $display("FAIL dtd_en_latency got=%0b exp=%0b", bus.dtd_en, exp_en);
    end
    ok = 1'b1;
  endtask

  // From the dtd_en cycle: deliver the DTD result, stall the consumer, then accept.
  task automatic finish_line(input int rdly, input int stall);
    repeat (rdly) @(negedge clk);
    bus.dtd_data_ready = 1'b1;
    @(negedge clk);
    bus.dtd_data_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL out_valid_rise got=%0b exp=1", bus.out_valid);
    end
    for (int k = 0; k < stall; k++) begin
      bus.dtd_data_ready = (k == 2);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.rd_req !== 1'b0 || bus.dtd_en !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold got=v%0b r%0b e%0b exp=v1 r0 e0",
                 bus.out_valid, bus.rd_req, bus.dtd_en);
      end
    end
    bus.dtd_data_ready = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL out_valid_drop got=%0b exp=0", bus.out_valid);
    end
  endtask

  // Runs one full bin; the model is the shortest prefix whose sum reaches BIN.
  task automatic run_bin(input logic [31:0] base, input sz_q_t sz, input bit rnd,
                         input int stall_line, input int stall, output int dur);
    int L = 0;
    int sum = 0;
    int d0, e0, t0, o0;
    bit ok;
    time tstart;
    logic [31:0] ea;
    dur = 0;
    while (sum < BIN && L < sz.size()) begin
      sum += int'(sz[L]);
      L++;
    end
    d0 = n_dtd; e0 = n_err; t0 = n_done; o0 = n_ovl;
    q_addr.delete();
    tstart = $time;
    start_bin(base);
    checks++;
    if (bus.bin_busy !== 1'b1 || bus.line_cnt !== 8'd0) begin
      failures++;
      $display("FAIL accept got=busy%0b cnt%0d exp=busy1 cnt0", bus.bin_busy, bus.line_cnt);
    end
    for (int i = 0; i < L; i++) begin
      serve_line(sz[i], (i == 0) ? 0 : 1,
                 rnd ? int'($urandom_range(0, 3)) : 1, rnd ? int'($urandom_range(0, 3)) : 1, ok);
      if (!ok) return;
      finish_line(rnd ? int'($urandom_range(0, 5)) : 1,
                  (i == stall_line) ? stall : (rnd ? int'($urandom_range(0, 3)) : 0));
    end
    @(negedge clk);
    dur = int'(($time - tstart) / 10);
    checks++;
    if (bus.bin_done !== 1'b1 || bus.bin_busy !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse got=done%0b busy%0b exp=done1 busy0", bus.bin_done, bus.bin_busy);
    end
    @(negedge clk);
    checks++;
    if (bus.bin_done !== 1'b0) begin
      failures++;
      $display("FAIL done_width got=%0b exp=0", bus.bin_done);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.line_cnt !== 8'(L)) begin
      failures++;
      $display("FAIL line_cnt got=%0d exp=%0d", bus.line_cnt, L);
    end
    checks++;
    if (q_addr.size() !== L) begin
      failures++;
      $display("FAIL rd_req_count got=%0d exp=%0d", q_addr.size(), L);
    end
    for (int i = 0; i < L && i < q_addr.size(); i++) begin
      ea = base + 32'(STRIDE * i);
      checks++;
      if (q_addr[i] !== ea) begin
        failures++;
        $display("FAIL rd_addr[%0d] got=%h exp=%h", i, q_addr[i], ea);
      end
    end
    checks++;
    if ((n_dtd - d0) !== L || (n_done - t0) !== 1 || (n_err - e0) !== 0 || n_ovl !== o0) begin
      failures++;
      $display("FAIL bin_events got=en%0d done%0d err%0d ovl%0d exp=en%0d done1 err0 ovl0",
               n_dtd - d0, n_done - t0, n_err - e0, n_ovl - o0, L);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.bin_busy, bus.bin_done, bus.bin_err, bus.rd_req, bus.dtd_en, bus.out_valid} !== 6'b0
        || bus.rd_addr !== 32'd0 || bus.line_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b addr=%h cnt=%0d exp=0",
               {bus.bin_busy, bus.bin_done, bus.bin_err, bus.rd_req, bus.dtd_en, bus.out_valid},
               bus.rd_addr, bus.line_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int dur;
    sz_q_t s = '{9'd100, 9'd100, 9'd100, 9'd100, 9'd100};
    run_bin(32'h0000_1000, s, 1'b0, -1, 0, dur);
  endtask

  task automatic test_overshoot;
    int dur;
    sz_q_t s = '{9'd300, 9'd150, 9'd200};
    run_bin(32'h0002_0000, s, 1'b0, -1, 0, dur);
  endtask

  task automatic test_backpressure;
    int dur_a, dur_b;
    sz_q_t s = '{9'd100, 9'd100, 9'd100, 9'd100};
    run_bin(32'h0000_4000, s, 1'b0, -1, 0, dur_a);
    run_bin(32'h0000_4000, s, 1'b0, 1, 10, dur_b);
    checks++;
    if (dur_b - dur_a !== 10) begin
      failures++;
      $display("FAIL stall_delay got=%0d exp=10", dur_b - dur_a);
    end
`ifdef DTD_SCHED_PERF_EN
    checks++;
    if (perf_stall !== 32'd10 || perf_cycles !== 32'(dur_b - 1)) begin
      failures++;
      $display("FAIL perf got=stall%0d cyc%0d exp=stall10 cyc%0d", perf_stall, perf_cycles, dur_b - 1);
    end
`endif
  endtask

  task automatic test_timeout;
    bit ok;
    int w = 0;
    int d0 = n_done;
    int dur;
    sz_q_t s = '{9'd200, 9'd250};
    start_bin(32'h0000_8000);
    serve_line(9'd100, 0, 1, 1, ok);
    while (!bus.bin_err && w < 100) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w !== TMO || bus.bin_busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err got=%0d busy%0b exp=%0d busy0", w, bus.bin_busy, TMO);
    end
    @(negedge clk);
    checks++;
    if (bus.bin_err !== 1'b0 || n_done !== d0 || bus.line_cnt !== 8'd0) begin
      failures++;
      $display("FAIL timeout_after got=err%0b done%0d cnt%0d exp=err0 done%0d cnt0",
               bus.bin_err, n_done, bus.line_cnt, d0);
    end
    // ready on the terminal-count cycle must complete the line
    start_bin(32'h0000_9000);
    serve_line(9'd450, 0, 0, 0, ok);
    d0 = n_err;
    finish_line(TMO - 1, 0);
    @(negedge clk);
    checks++;
    if (bus.bin_done !== 1'b1 || n_err !== d0) begin
      failures++;
      $display("FAIL ready_wins got=done%0b err%0d exp=done1 err%0d", bus.bin_done, n_err, d0);
    end
    repeat (2) @(negedge clk);
    run_bin(32'h0000_A000, s, 1'b1, -1, 0, dur);
  endtask

  task automatic test_zero_size;
    bit ok;
    int d0 = n_dtd;
    start_bin(32'h0000_C000);
    serve_line(9'd0, 0, 1, 1, ok);
    checks++;
    if (bus.bin_err !== 1'b1 || bus.bin_done !== 1'b0) begin
      failures++;
      $display("FAIL zero_err got=err%0b done%0b exp=err1 done0", bus.bin_err, bus.bin_done);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (n_dtd !== d0 || bus.bin_busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_no_dtd got=%0d busy%0b exp=%0d busy0", n_dtd, bus.bin_busy, d0);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int d0 = n_done;
    int e0 = n_err;
    start_bin(32'h0000_E000);
    serve_line(9'd100, 0, 1, 1, ok);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.dtd_data_ready = 1'b1;
    @(negedge clk);
    bus.dtd_data_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({bus.bin_busy, bus.bin_done, bus.bin_err, bus.rd_req, bus.dtd_en, bus.out_valid} !== 6'b0
          || bus.rd_addr !== 32'd0 || bus.line_cnt !== 8'd0) begin
        failures++;
        $display("FAIL reset_mid got=%b addr=%h cnt=%0d exp=0",
                 {bus.bin_busy, bus.bin_done, bus.bin_err, bus.rd_req, bus.dtd_en, bus.out_valid},
                 bus.rd_addr, bus.line_cnt);
      end
      @(negedge clk);
    end
    checks++;
    if (n_done !== d0 || n_err !== e0) begin
      failures++;
      $display("FAIL reset_mid_pulses got=done%0d err%0d exp=done%0d err%0d", n_done, n_err, d0, e0);
    end
  endtask

  task automatic test_wrap;
    int dur;
    sz_q_t s = '{9'd200, 9'd250};
    run_bin(32'hFFFF_FFE0, s, 1'b0, -1, 0, dur);
  endtask

  task automatic test_random;
    int dur;
    int sum;
    sz_q_t s;
    for (int b = 0; b < 8; b++) begin
      s.delete();
      sum = 0;
      while (sum < BIN + 100) begin
        s.push_back(9'($urandom_range(20, 511)));
        sum += int'(s[s.size() - 1]);
      end
      run_bin($urandom, s, 1'b1, -1, 0, dur);
    end
  endtask

  initial begin
    bus.bin_req = 1'b0;
    bus.bin_base = '0;
    bus.rd_gnt = 1'b0;
    bus.rd_valid = 1'b0;
    bus.rd_size = '0;
    bus.dtd_data_ready = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    test_basic;
    test_overshoot;
    test_backpressure;
    test_timeout;
    test_zero_size;
    test_reset_mid;
    test_wrap;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
